flash_cmd_seq: RTL and testbench

FLASH_CMD_SEQ -- requirements
Module: flash_cmd_seq

---
 rtl/flash_cmd_seq.sv | 211 +++++++++++++++++++++
 tb/tb_flash_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_seq.sv
// SPI flash command sequencer: WREN / erase command / status polling with a fixed idle gap between polls.
// Optional poll-count timeout is compiled in when FLASH_TIMEOUT_EN is defined.
module flash_cmd_seq #(
    parameter int POLL_GAP  = 1000,
    parameter int MAX_POLLS = 65535
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [23:0]  addr,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   status,
    output logic         spi_trig,
    output logic [7:0]   spi_len,
    output logic [127:0] spi_tx,
    input  logic         spi_busy,
    input  logic [127:0] spi_rx
);

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_CMD,
        S_POLL,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_XFER,
        PH_WAIT
    } phase_t;

    state_t         state, state_nx;
    phase_t         phase, phase_nx;
    logic [1:0]     op_q;
    logic [23:0]    addr_q;
    logic [7:0]     status_q;
    logic           err_q, err_nx;
    logic [GW-1:0]  gap_cnt;
    logic           xfer_done;
    logic           wip;
    logic           poll_limit;
    logic [119:0]   rx_unused;

    assign xfer_done = (phase == PH_WAIT) && !spi_busy;
    assign wip       = spi_rx[0];
    assign rx_unused = spi_rx[127:8];

`ifdef FLASH_TIMEOUT_EN
    localparam int PW = $clog2(MAX_POLLS + 1);
    logic [PW-1:0] poll_cnt;

    // Counts completed polls of the current request; the limit fires on the last allowed one.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            poll_cnt <= '0;
        end else if (state == S_POLL && xfer_done) begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign poll_limit = (poll_cnt == PW'(MAX_POLLS - 1));
`else
    logic [31:0] max_polls_unused;
    assign max_polls_unused = MAX_POLLS;
    assign poll_limit       = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            phase <= PH_XFER;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        err_nx   = err_q;
        spi_trig = 1'b0;
        spi_len  = 8'd0;
        spi_tx   = '0;

        // Command framing; held constant for the whole XFER+WAIT of each state.
        case (state)
            S_WREN: begin
                spi_len     = 8'd8;
                spi_tx[7:0] = 8'h06;
            end
            S_CMD: begin
                if (op_q == 2'd1) begin
                    spi_len      = 8'd32;
                    spi_tx[31:0] = {8'h20, addr_q};
                end else begin
                    spi_len     = 8'd8;
                    spi_tx[7:0] = 8'hC7;
                end
            end
            S_POLL: begin
                spi_len      = 8'd16;
                spi_tx[15:0] = 16'h0500;
            end
            default: ;
        endcase

        if (state == S_WREN || state == S_CMD || state == S_POLL) begin
            spi_trig = (phase == PH_XFER);
            if (phase == PH_XFER && spi_busy) begin
                phase_nx = PH_WAIT;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    err_nx   = 1'b0;
                    phase_nx = PH_XFER;
                    case (op)
                        2'd0, 2'd1: state_nx = S_WREN;
                        2'd2:       state_nx = S_POLL;
                        default: begin
                            state_nx = S_DONE;
                            err_nx   = 1'b1;
                        end
                    endcase
                end
            end
            S_WREN: begin
                if (xfer_done) begin
                    state_nx = S_CMD;
                    phase_nx = PH_XFER;
                end
            end
            S_CMD: begin
                if (xfer_done) begin
                    state_nx = S_POLL;
                    phase_nx = PH_XFER;
                end
            end
            S_POLL: begin
                if (xfer_done) begin
                    phase_nx = PH_XFER;
                    if (op_q == 2'd2 || !wip) begin
                        state_nx = S_DONE;
                        err_nx   = 1'b0;
                    end else if (poll_limit) begin
                        state_nx = S_DONE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(POLL_GAP - 1)) begin
                    state_nx = S_POLL;
                    phase_nx = PH_XFER;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = PH_XFER;
            end
        endcase
    end

    // Request capture, status latch and gap timer.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            op_q     <= 2'd0;
            addr_q   <= 24'd0;
            status_q <= 8'd0;
            err_q    <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            err_q <= err_nx;
            if (state == S_IDLE && start) begin
                op_q   <= op;
                addr_q <= addr;
            end
            if (state == S_POLL && xfer_done) begin
                status_q <= spi_rx[7:0];
            end
            if (state == S_GAP && state_nx == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = (state == S_DONE) && err_q;
    assign status = status_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Self-checking bench for flash_cmd_seq: SPI shifter + flash status model, vector table plus reset corner case.
module tb_flash_cmd_seq;

    localparam int POLL_GAP  = 6;
    localparam int MAX_POLLS = 4;

    logic         sclk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [23:0]  addr;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   status;
    logic         spi_trig;
    logic [7:0]   spi_len;
    logic [127:0] spi_tx;
    logic         spi_busy;
    logic [127:0] spi_rx;

    flash_cmd_seq #(
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .status   (status),
        .spi_trig (spi_trig),
        .spi_len  (spi_len),
        .spi_tx   (spi_tx),
        .spi_busy (spi_busy),
        .spi_rx   (spi_rx)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        int          wip;
        logic [7:0]  sbase;
        bit          poke;
        int          exp_xfers;
        logic        exp_err;
        logic [7:0]  exp_status;
        logic [7:0]  exp_len0;
        logic [31:0] exp_tx0;
        logic [7:0]  exp_len1;
        logic [31:0] exp_tx1;
    } vec_t;

    int           passed = 0;
    int           total  = 0;

    int           cyc;
    int           log_n;
    logic [7:0]   log_len [32];
    logic [127:0] log_tx  [32];
    int           log_beg [32];
    int           log_end [32];
    int           stab_err;
    int           wip_left;
    logic [7:0]   sbase;
    bit           model_abort;
    int           mcnt;
    int           cur;

    logic         got_done, got_busy, got_err, after_busy, after_done;
    logic [7:0]   got_status;
    int           got_latency;

    // SPI shifter: 3-cycle busy per transfer, driven on the falling edge; polls answer from the flash model.
    initial begin
        spi_busy    = 1'b0;
        spi_rx      = '0;
        cyc         = 0;
        log_n       = 0;
        stab_err    = 0;
        mcnt        = 0;
        cur         = 0;
        model_abort = 1'b0;
        wip_left    = 0;
        sbase       = 8'h00;
        forever begin
            @(negedge sclk);
            cyc++;
            if (model_abort) begin
                spi_busy    = 1'b0;
                mcnt        = 0;
                model_abort = 1'b0;
            end else if (spi_busy) begin
                if (spi_trig || spi_len != log_len[cur] || spi_tx != log_tx[cur]) stab_err++;
                mcnt--;
                if (mcnt == 0) begin
                    spi_busy     = 1'b0;
                    log_end[cur] = cyc;
                end
            end else if (spi_trig) begin
                cur          = (log_n < 31) ? log_n : 31;
                log_len[cur] = spi_len;
                log_tx[cur]  = spi_tx;
                log_beg[cur] = cyc;
                log_n++;
                if (spi_len == 8'd16 && spi_tx[15:8] == 8'h05) begin
                    if (wip_left > 0) begin
                        spi_rx = {120'd0, sbase | 8'h01};
                        wip_left--;
                    end else begin
                        spi_rx = {120'd0, sbase & 8'hFE};
                    end
                end else begin
                    spi_rx = {120'd0, 8'hFF};
                end
                spi_busy = 1'b1;
                mcnt     = 3;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        @(negedge sclk);
        log_n    = 0;
        stab_err = 0;
        wip_left = v.wip;
        sbase    = v.sbase;
        start    = 1'b1;
        op       = v.op;
        addr     = v.addr;
        @(negedge sclk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 2000) begin
            if (v.poke && n == 10) begin
                start = 1'b1;
                op    = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge sclk);
            n++;
        end
        start       = 1'b0;
        got_done    = done;
        got_busy    = busy;
        got_err     = err;
        got_status  = status;
        got_latency = n;
        if (v.poke) begin
            start = 1'b1;
            op    = 2'd3;
        end
        @(negedge sclk);
        start      = 1'b0;
        after_busy = busy;
        after_done = done;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int lim;
        applyStimulus(v);
        checkOutput($sformatf("v%0d_done", idx), 128'(got_done), 128'(1));
        checkOutput($sformatf("v%0d_busy_in_done", idx), 128'(got_busy), 128'(1));
        checkOutput($sformatf("v%0d_err", idx), 128'(got_err), 128'(v.exp_err));
        checkOutput($sformatf("v%0d_status", idx), 128'(got_status), 128'(v.exp_status));
        checkOutput($sformatf("v%0d_xfers", idx), 128'(log_n), 128'(v.exp_xfers));
        checkOutput($sformatf("v%0d_stable", idx), 128'(stab_err), 128'(0));
        checkOutput($sformatf("v%0d_idle_after", idx), 128'(after_busy), 128'(0));
        checkOutput($sformatf("v%0d_done_width", idx), 128'(after_done), 128'(0));
        if (v.op == 2'd3) begin
            checkOutput($sformatf("v%0d_latency_le2", idx), 128'(got_latency <= 2), 128'(1));
        end
        if (v.exp_xfers >= 1 && log_n >= 1) begin
            checkOutput($sformatf("v%0d_len0", idx), 128'(log_len[0]), 128'(v.exp_len0));
            checkOutput($sformatf("v%0d_tx0", idx), log_tx[0], 128'(v.exp_tx0));
        end
        if (v.exp_xfers >= 2 && log_n >= 2) begin
            checkOutput($sformatf("v%0d_len1", idx), 128'(log_len[1]), 128'(v.exp_len1));
            checkOutput($sformatf("v%0d_tx1", idx), log_tx[1], 128'(v.exp_tx1));
        end
        lim = (log_n < 32) ? log_n : 32;
        for (int i = 2; i < lim; i++) begin
            checkOutput($sformatf("v%0d_poll%0d_tx", idx, i), log_tx[i], 128'(32'h0500));
            checkOutput($sformatf("v%0d_poll%0d_len", idx, i), 128'(log_len[i]), 128'(16));
        end
        for (int i = 1; i < lim; i++) begin
            checkOutput($sformatf("v%0d_spacing%0d", idx, i), 128'(log_beg[i] - log_end[i-1]),
                        128'((i >= 3) ? POLL_GAP + 1 : 1));
        end
    endtask

    vec_t vecs[7];
    vec_t post_rst;

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        addr  = 24'd0;

        vecs[0] = '{2'd0, 24'h000000, 3, 8'h00, 1'b0, 6, 1'b0, 8'h00, 8'd8, 32'h06, 8'd8, 32'hC7};
        vecs[1] = '{2'd1, 24'h123456, 2, 8'h00, 1'b1, 5, 1'b0, 8'h00, 8'd8, 32'h06, 8'd32, 32'h2012_3456};
        vecs[2] = '{2'd2, 24'h000000, 1, 8'h02, 1'b0, 1, 1'b0, 8'h03, 8'd16, 32'h0500, 8'd0, 32'h0};
        vecs[3] = '{2'd3, 24'h000000, 0, 8'h00, 1'b0, 0, 1'b1, 8'h03, 8'd0, 32'h0, 8'd0, 32'h0};
        vecs[4] = '{2'd0, 24'h000000, 0, 8'hA4, 1'b1, 3, 1'b0, 8'hA4, 8'd8, 32'h06, 8'd8, 32'hC7};
        vecs[5] = '{2'd1, 24'hFFFFFF, 0, 8'h00, 1'b0, 3, 1'b0, 8'h00, 8'd8, 32'h06, 8'd32, 32'h20FF_FFFF};
`ifdef FLASH_TIMEOUT_EN
        vecs[6] = '{2'd0, 24'h000000, 6, 8'h00, 1'b0, 6, 1'b1, 8'h01, 8'd8, 32'h06, 8'd8, 32'hC7};
`else
        vecs[6] = '{2'd0, 24'h000000, 6, 8'h00, 1'b0, 9, 1'b0, 8'h00, 8'd8, 32'h06, 8'd8, 32'hC7};
`endif
        post_rst = '{2'd2, 24'h000000, 0, 8'h40, 1'b0, 1, 1'b0, 8'h40, 8'd16, 32'h0500, 8'd0, 32'h0};

        repeat (3) @(negedge sclk);
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_err", 128'(err), 128'(0));
        checkOutput("rst_status", 128'(status), 128'(0));
        checkOutput("rst_trig", 128'(spi_trig), 128'(0));
        checkOutput("rst_len", 128'(spi_len), 128'(0));
        checkOutput("rst_tx", spi_tx, 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runVector(i, vecs[i]);
        end

        // Reset while the erase command is in its WAIT phase, then a clean status-only request.
        @(negedge sclk);
        log_n    = 0;
        stab_err = 0;
        wip_left = 0;
        sbase    = 8'h00;
        start    = 1'b1;
        op       = 2'd0;
        @(negedge sclk);
        start = 1'b0;
        n     = 0;
        while (log_n < 2 && n < 200) begin
            @(negedge sclk);
            n++;
        end
        checkOutput("midrst_cmd_reached", 128'(log_n >= 2), 128'(1));
        @(negedge sclk);
        checkOutput("midrst_in_wait", 128'(busy && !spi_trig && spi_len == 8'd8), 128'(1));
        rst_n       = 1'b0;
        model_abort = 1'b1;
        @(negedge sclk);
        checkOutput("midrst_busy", 128'(busy), 128'(0));
        checkOutput("midrst_trig", 128'(spi_trig), 128'(0));
        checkOutput("midrst_done", 128'(done), 128'(0));
        checkOutput("midrst_len", 128'(spi_len), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        runVector(7, post_rst);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
